// File: rtl/tile_pkg.sv
// tile_pkg: shared types and helpers for the per-tile search engine.
//   seeker_state_t : one-hot FSM state encoding.
//   onehot_next()  : advances a one-hot pool index and flags exhaustion.
//   GRID_LEN/CNT_W : grid row length and the matching attempt-counter width.
// GRID_LEN normally comes from grid_dimensions.svh; fall back to a 4-wide
// grid when that header has not been pulled in ahead of this package.
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

package tile_pkg;

    localparam int GRID_LEN = `GRID_LEN;
    localparam int CNT_W    = $clog2(GRID_LEN + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_REQUEST = 4'b0010,
        S_CHECK   = 4'b0100,
        S_HOLD    = 4'b1000
    } seeker_state_t;

    typedef struct packed {
        logic                exhaust;
        logic [GRID_LEN-1:0] next;
    } onehot_step_t;

    // Shifting the MSB out means every candidate index has been tried; the
    // next index is then forced to zero so the bus sees an idle request.
    function automatic onehot_step_t onehot_next(input logic [GRID_LEN-1:0] rqindex);
        onehot_step_t r;
        r.exhaust = rqindex[GRID_LEN-1];
        r.next    = r.exhaust ? '0 : (rqindex << 1);
        return r;
    endfunction

endpackage

// File: rtl/tile_seeker.sv
// tile_seeker: per-tile search engine on the row value-bias bus.
// Walks one-hot pool indices LSB->MSB, asks the bus for the biased value of
// each index, and commits the first one not already held by a peer.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   start             : (re)start the search at index 0
//   backtrack         : next tile gave up; drop our value and try the next index
//   occupied [W]      : OR of peer values (sampled only while checking)
//   update            : bus request strobe
//   rqindex  [W]      : one-hot pool index being requested (0 when idle)
//   valtotry [W]      : bus return value, valid the cycle after update
//   value    [W]      : committed one-hot value (0 when none)
//   pass_fwd          : one-cycle pulse, value committed
//   pass_back         : one-cycle pulse, all candidates exhausted
//   busy              : search in progress (REQUEST or CHECK)
//   tries    [CNT_W]  : candidates examined since the last start
// WIDTH must match GRID_LEN because the index stepping helper is sized by it.
module tile_seeker
    import tile_pkg::*;
#(
    parameter int WIDTH = GRID_LEN,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             backtrack,
    input  logic [WIDTH-1:0] occupied,
    output logic             update,
    output logic [WIDTH-1:0] rqindex,
    input  logic [WIDTH-1:0] valtotry,
    output logic [WIDTH-1:0] value,
    output logic             pass_fwd,
    output logic             pass_back,
    output logic             busy,
    output logic [CNT_W-1:0] tries
);

    seeker_state_t state;
    onehot_step_t  step;
    logic          accept;
    logic          advance;

    assign step    = onehot_next(rqindex);
    assign accept  = ((valtotry & occupied) == '0) && (valtotry != '0);
    // A rejected candidate and a backtrack from HOLD share the same
    // move-to-next-index-or-give-up path.
    assign advance = ((state == S_CHECK) && !accept) ||
                     ((state == S_HOLD) && backtrack);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            update    <= 1'b0;
            rqindex   <= '0;
            value     <= '0;
            pass_fwd  <= 1'b0;
            pass_back <= 1'b0;
            busy      <= 1'b0;
            tries     <= '0;
        end else begin
            update    <= 1'b0;
            pass_fwd  <= 1'b0;
            pass_back <= 1'b0;

            if (state == S_CHECK)
                tries <= (tries == CNT_W'(WIDTH)) ? tries : tries + 1'b1;

            if (start) begin
                state   <= S_REQUEST;
                rqindex <= WIDTH'(1);
                value   <= '0;
                tries   <= '0;
                update  <= 1'b1;
                busy    <= 1'b1;
            end else if (advance) begin
                value <= '0;
                if (step.exhaust) begin
                    state     <= S_IDLE;
                    rqindex   <= '0;
                    pass_back <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    state   <= S_REQUEST;
                    rqindex <= step.next;
                    update  <= 1'b1;
                    busy    <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE:    ;
                    // rqindex stays put so the bus answers for this index.
                    S_REQUEST: state <= S_CHECK;
                    S_CHECK: begin
                        // Only reached here on accept; rejects took the advance path.
                        state    <= S_HOLD;
                        value    <= valtotry;
                        pass_fwd <= 1'b1;
                        busy     <= 1'b0;
                    end
                    S_HOLD:    ;
                    default: begin
                        state   <= S_IDLE;
                        rqindex <= '0;
                        value   <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_seeker.sv
// tb_tile_seeker: randomized and directed checks of tile_seeker against a
// transaction-level model of the search (expected outputs per cycle).
module tb_tile_seeker;

    localparam int W    = 4;
    localparam int CW   = 3;
    localparam int NCYC = 3000;
    localparam logic [1:0] M_IDLE = 2'd0, M_BUSY = 2'd1, M_HOLD = 2'd2;

    logic          clock, reset, start, backtrack;
    logic [W-1:0]  occupied, rqindex, valtotry, value;
    logic          update, pass_fwd, pass_back, busy;
    logic [CW-1:0] tries;

    tile_seeker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .start(start), .backtrack(backtrack),
        .occupied(occupied), .update(update), .rqindex(rqindex),
        .valtotry(valtotry), .value(value), .pass_fwd(pass_fwd),
        .pass_back(pass_back), .busy(busy), .tries(tries)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bias-bus model: fixed pool, answer registered on the update strobe.
    logic [W-1:0] pool [W];
    initial begin
        pool[0] = 4'b0100; pool[1] = 4'b0001; pool[2] = 4'b1000; pool[3] = 4'b0010;
    end

    logic vt_valid;
    initial begin valtotry = '0; vt_valid = 1'b0; end
    always @(posedge clock) begin
        vt_valid <= update;
        if (update)
            for (int i = 0; i < W; i++)
                if (rqindex == (W'(1) << i)) valtotry <= pool[i];
    end
    always @(negedge clock)
        if (vt_valid) assert ($onehot(valtotry)) else $error("valtotry not one-hot");

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    int upd_cnt = 0, pf_cnt = 0, pb_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, expv);
        end
    endtask

    // Expected outputs per cycle, planned from the search rules.
    typedef struct packed {
        logic          upd;
        logic [W-1:0]  rq;
        logic [W-1:0]  val;
        logic          pf;
        logic          pb;
        logic          bsy;
        logic [CW-1:0] tr;
        logic [1:0]    mode;
        logic [1:0]    hidx;
    } exp_t;
    exp_t ex [NCYC];

    function automatic exp_t idle_exp(input int tr);
        exp_t e;
        e = '0;
        e.tr = CW'(tr);
        e.mode = M_IDLE;
        return e;
    endfunction

    task automatic put(input int t, input exp_t e);
        if (t >= 0 && t < NCYC) ex[t] = e;
    endtask

    task automatic fill(input int from, input exp_t e);
        for (int t = from; t < NCYC; t++) ex[t] = e;
    endtask

    task automatic exhaust(input int t, input int tr);
        exp_t e;
        e = idle_exp(tr);
        e.pb = 1'b1;
        put(t, e);
        e.pb = 1'b0;
        fill(t + 1, e);
    endtask

    // Search beginning with candidate k, inputs sampled at the end of cycle c.
    task automatic plan(input int c, input int k, input int t0);
        exp_t e;
        int t, tr;
        t = c + 1; tr = t0;
        for (int i = k; i < W; i++) begin
            e = '0;
            e.upd = 1'b1; e.rq = W'(1) << i; e.bsy = 1'b1; e.tr = CW'(tr); e.mode = M_BUSY;
            put(t, e); t++;
            e.upd = 1'b0;
            put(t, e); t++;
            tr++;
            if ((pool[i] & occupied) == '0) begin
                e.val = pool[i]; e.pf = 1'b1; e.bsy = 1'b0; e.tr = CW'(tr);
                e.mode = M_HOLD; e.hidx = 2'(i);
                put(t, e);
                e.pf = 1'b0;
                fill(t + 1, e);
                return;
            end
        end
        exhaust(t, tr);
    endtask

    task automatic model(input int c, input logic s, input logic b, input logic r);
        if (r) fill(c + 1, idle_exp(0));
        else if (s) plan(c, 0, 0);
        else if (b && ex[c].mode == M_HOLD) begin
            if (int'(ex[c].hidx) == W - 1) exhaust(c + 1, int'(ex[c].tr));
            else plan(c, int'(ex[c].hidx) + 1, int'(ex[c].tr));
        end
    endtask

    // One cycle of stimulus: inputs are sampled at the next posedge.
    task automatic step(input logic s, input logic b, input logic r);
        start = s; backtrack = b; reset = r;
        model(cyc, s, b, r);
        @(negedge clock);
        start = 1'b0; backtrack = 1'b0; reset = 1'b0;
        if (update)    upd_cnt++;
        if (pass_fwd)  pf_cnt++;
        if (pass_back) pb_cnt++;
    endtask

    task automatic clr_cnt();
        upd_cnt = 0; pf_cnt = 0; pb_cnt = 0;
    endtask

    always @(negedge clock) begin
        if (cyc >= 1 && cyc < NCYC) begin
            chk("update",    32'(update),    32'(ex[cyc].upd));
            chk("rqindex",   32'(rqindex),   32'(ex[cyc].rq));
            chk("value",     32'(value),     32'(ex[cyc].val));
            chk("pass_fwd",  32'(pass_fwd),  32'(ex[cyc].pf));
            chk("pass_back", 32'(pass_back), 32'(ex[cyc].pb));
            chk("busy",      32'(busy),      32'(ex[cyc].bsy));
            chk("tries",     32'(tries),     32'(ex[cyc].tr));
        end
    end

    initial begin
        fill(0, idle_exp(0));
        reset = 1'b1; start = 1'b0; backtrack = 1'b0; occupied = '0;
        @(negedge clock);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("reset_value", 32'(value), 32'h0);

        // Scenario 1: first candidate accepted.
        occupied = 4'b0000;
        step(1, 0, 0);
        chk("s1_update", 32'(update), 32'h1);
        chk("s1_rq", 32'(rqindex), 32'h1);
        step(0, 0, 0); step(0, 0, 0);
        chk("s1_value", 32'(value), 32'h4);
        chk("s1_pf", 32'(pass_fwd), 32'h1);
        chk("s1_tries", 32'(tries), 32'h1);
        chk("s1_busy", 32'(busy), 32'h0);

        // Scenario 2: two rejects then accept at index 2.
        occupied = 4'b0101;
        clr_cnt();
        step(1, 0, 0);
        repeat (7) step(0, 0, 0);
        chk("s2_value", 32'(value), 32'h8);
        chk("s2_tries", 32'(tries), 32'h3);
        chk("s2_updates", 32'(upd_cnt), 32'd3);
        chk("s2_pf_cnt", 32'(pf_cnt), 32'd1);

        // Scenario 4: backtrack to index 3, then exhaust.
        step(0, 1, 0);
        chk("s4_value0", 32'(value), 32'h0);
        chk("s4_rq", 32'(rqindex), 32'h8);
        step(0, 0, 0); step(0, 0, 0);
        chk("s4_value", 32'(value), 32'h2);
        step(0, 1, 0);
        chk("s4_pb", 32'(pass_back), 32'h1);
        chk("s4_rq0", 32'(rqindex), 32'h0);
        step(0, 0, 0);

        // Scenario 3: everything occupied.
        occupied = 4'b1111;
        clr_cnt();
        step(1, 0, 0);
        repeat (8) step(0, 0, 0);
        chk("s3_pb", 32'(pass_back), 32'h1);
        chk("s3_value", 32'(value), 32'h0);
        chk("s3_rq", 32'(rqindex), 32'h0);
        chk("s3_updates", 32'(upd_cnt), 32'd4);
        chk("s3_pf_cnt", 32'(pf_cnt), 32'd0);
        step(0, 0, 0);

        // Scenario 5: start+backtrack in HOLD, reset in CHECK, backtrack in IDLE.
        occupied = 4'b0000;
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(1, 1, 0);
        chk("s5_rq", 32'(rqindex), 32'h1);
        chk("s5_update", 32'(update), 32'h1);
        step(0, 0, 0);
        clr_cnt();
        step(0, 0, 1);
        chk("s5_rst_busy", 32'(busy), 32'h0);
        chk("s5_rst_rq", 32'(rqindex), 32'h0);
        step(0, 0, 0);
        chk("s5_no_pulse", 32'(pf_cnt + pb_cnt), 32'd0);
        clr_cnt();
        step(0, 1, 0); step(0, 0, 0);
        chk("s5_idle_bt", 32'(upd_cnt), 32'd0);

        // Randomized traffic; occupied only moves while no search is running.
        while (cyc < NCYC - 40) begin
            logic s, b, r;
            if (ex[cyc].mode != M_BUSY && $urandom_range(0, 3) == 0)
                occupied = W'($urandom & $urandom);
            r = ($urandom_range(0, 79) == 0);
            s = ($urandom_range(0, 9) == 0);
            b = ($urandom_range(0, 3) == 0);
            step(s, b, r);
        end
        repeat (2) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
